// File: rtl/mips_dmem_responder.sv
// Data-memory responder: slave end of the MIPS core load/store port.
// Latency: response valid in the cycle after edge accept+WAIT_CYCLES+1; one request per WAIT_CYCLES+3 cycles.
// Backpressure: req_ready low while a request is in flight; the response cannot be stalled.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake (accepted when both high on a rising edge)
//   req_write             - 1 = store, 0 = load
//   req_addr              - byte address (must be word aligned and inside the array)
//   req_wdata, req_be     - store data and per-byte enables
//   rsp_valid             - one-cycle response strobe
//   rsp_rdata             - load data (0 for stores and faults)
//   rsp_err               - misaligned or out-of-range request
module mips_dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];
    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // A word address is usable only if aligned and all bits above the array are zero.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        wr_from_idle;
    logic        wr_from_wait;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic        lat_bad;

    assign accept  = (state_q == S_IDLE) && req_ready_q && req_valid;
    assign rd_idx  = addr_q[ADDR_WIDTH+1:2];
    assign lat_bad = addr_bad(addr_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_LD;
                    state_d = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is registered from the state, so it appears one edge after the
    // FSM lands in IDLE (both after reset and after a response).
    assign req_ready_d = (state_q == S_IDLE) && !accept;

    // The store commits on the edge that enters RESP. With no wait states that
    // edge is the accept edge itself, so the live request fields are used.
    always_comb begin
        wr_from_idle = accept && NO_WAIT;
        wr_from_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);
        wr_addr      = wr_from_idle ? req_addr  : addr_q;
        wr_data      = wr_from_idle ? req_wdata : wdata_q;
        wr_be        = wr_from_idle ? req_be    : be_q;
        wr_en        = (wr_from_idle ? req_write : (wr_from_wait && write_q))
                       && !addr_bad(wr_addr);
        wr_idx       = wr_addr[ADDR_WIDTH+1:2];
    end

    // Response is registered out of RESP; the array read happens after any
    // store of this transaction has already been committed.
    always_comb begin
        rsp_valid_d = (state_q == S_RESP);
        rsp_err_d   = (state_q == S_RESP) && lat_bad;
        rsp_rdata_d = 32'd0;
        if ((state_q == S_RESP) && !lat_bad && !write_q) begin
            rsp_rdata_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Array contents survive reset. wr_en cannot fire during reset because
    // the FSM is held in IDLE with req_ready low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
